// File: rtl/qkv_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : qkv_feeder
//  Description : Streams one Q vector per query row followed by the full K/V
//                sequence from three 1-cycle-latency SRAM read ports into the
//                valid/ready inputs of a single PE. Each channel owns a
//                2-entry output FIFO so reads can be issued back-to-back.
//  Revision    : 1.0 - initial release
// ============================================================================
module qkv_feeder #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 2,
  parameter int Q_VEC_W    = 64,
  parameter int K_VEC_W    = 64,
  parameter int V_VEC_W    = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W:0]    num_q,
  input  logic [ADDR_W:0]    seq_len,
  output logic               busy,
  output logic               done,
  output logic               q_sram_re,
  output logic               k_sram_re,
  output logic               v_sram_re,
  output logic [ADDR_W-1:0]  q_sram_addr,
  output logic [ADDR_W-1:0]  k_sram_addr,
  output logic [ADDR_W-1:0]  v_sram_addr,
  input  logic [Q_VEC_W-1:0] q_sram_rdata,
  input  logic [K_VEC_W-1:0] k_sram_rdata,
  input  logic [V_VEC_W-1:0] v_sram_rdata,
  output logic               Q_vld_out,
  output logic               K_vld_out,
  output logic               V_vld_out,
  input  logic               Q_rdy_in,
  input  logic               K_rdy_in,
  input  logic               V_rdy_in,
  output logic [Q_VEC_W-1:0] q_vector,
  output logic [K_VEC_W-1:0] k_vector,
  output logic [V_VEC_W-1:0] v_vector
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_Q_PHASE  = 2'd1,
    S_KV_PHASE = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] c_one   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [2:0]      c_depth = 3'(FIFO_DEPTH);

  state_t r_state;
  state_t w_state_nx;

  logic [ADDR_W:0] r_num_q;
  logic [ADDR_W:0] r_seq_len;
  logic [ADDR_W:0] r_q_idx;
  logic            r_q_issued;
  logic [ADDR_W:0] r_k_iss;
  logic [ADDR_W:0] r_v_iss;
  logic [ADDR_W:0] r_k_hs;
  logic [ADDR_W:0] r_v_hs;
  logic            r_q_inflight;
  logic            r_k_inflight;
  logic            r_v_inflight;

  logic [1:0]      w_q_cnt;
  logic [1:0]      w_k_cnt;
  logic [1:0]      w_v_cnt;
  logic            w_q_pop;
  logic            w_k_pop;
  logic            w_v_pop;
  logic            w_q_re;
  logic            w_k_re;
  logic            w_v_re;
  logic [ADDR_W:0] w_k_hs_nx;
  logic [ADDR_W:0] w_v_hs_nx;
  logic            w_accept;
  logic            w_zero_job;
  logic            w_kv_last;
  logic            w_last_q;
  logic [2:0]      w_k_load;
  logic [2:0]      w_v_load;
  logic [2:0]      w_k_lim;
  logic [2:0]      w_v_lim;

  // Handshakes and job-level decode
  assign w_q_pop    = Q_vld_out & Q_rdy_in;
  assign w_k_pop    = K_vld_out & K_rdy_in;
  assign w_v_pop    = V_vld_out & V_rdy_in;
  assign w_accept   = (r_state == S_IDLE) & start;
  assign w_zero_job = (num_q == '0) | (seq_len == '0);
  assign w_last_q   = (r_q_idx == (r_num_q - c_one));

  // A slot freed by a pop this cycle may be reused by a read this cycle;
  // this keeps the stream bubble-free with one read always in flight.
  assign w_k_load = {1'b0, w_k_cnt} + {2'b00, r_k_inflight};
  assign w_v_load = {1'b0, w_v_cnt} + {2'b00, r_v_inflight};
  assign w_k_lim  = c_depth + {2'b00, w_k_pop};
  assign w_v_lim  = c_depth + {2'b00, w_v_pop};

  assign w_q_re = (r_state == S_Q_PHASE) & ~r_q_issued;
  assign w_k_re = (r_state == S_KV_PHASE) & (r_k_iss < r_seq_len) & (w_k_load < w_k_lim);
  assign w_v_re = (r_state == S_KV_PHASE) & (r_v_iss < r_seq_len) & (w_v_load < w_v_lim);

  assign w_k_hs_nx = r_k_hs + {{ADDR_W{1'b0}}, w_k_pop};
  assign w_v_hs_nx = r_v_hs + {{ADDR_W{1'b0}}, w_v_pop};
  assign w_kv_last = (r_state == S_KV_PHASE) & (w_k_hs_nx == r_seq_len) & (w_v_hs_nx == r_seq_len);

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state decode: one Q handshake, then a full K/V sweep, per query row
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nx = w_zero_job ? S_DONE : S_Q_PHASE;
        end
      end
      S_Q_PHASE: begin
        if (w_q_pop) begin
          w_state_nx = S_KV_PHASE;
        end
      end
      S_KV_PHASE: begin
        if (w_kv_last) begin
          w_state_nx = w_last_q ? S_DONE : S_Q_PHASE;
        end
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // Job parameters, row indices, issue/handshake counters and in-flight flags
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_num_q      <= '0;
      r_seq_len    <= '0;
      r_q_idx      <= '0;
      r_q_issued   <= 1'b0;
      r_k_iss      <= '0;
      r_v_iss      <= '0;
      r_k_hs       <= '0;
      r_v_hs       <= '0;
      r_q_inflight <= 1'b0;
      r_k_inflight <= 1'b0;
      r_v_inflight <= 1'b0;
    end else begin
      r_q_inflight <= w_q_re;
      r_k_inflight <= w_k_re;
      r_v_inflight <= w_v_re;

      if (w_accept && !w_zero_job) begin
        r_num_q    <= num_q;
        r_seq_len  <= seq_len;
        r_q_idx    <= '0;
        r_q_issued <= 1'b0;
      end

      if (w_q_re) begin
        r_q_issued <= 1'b1;
      end

      if (w_q_pop) begin
        r_k_iss <= '0;
        r_v_iss <= '0;
        r_k_hs  <= '0;
        r_v_hs  <= '0;
      end else begin
        if (w_k_re) begin
          r_k_iss <= r_k_iss + c_one;
        end
        if (w_v_re) begin
          r_v_iss <= r_v_iss + c_one;
        end
        r_k_hs <= w_k_hs_nx;
        r_v_hs <= w_v_hs_nx;
      end

      if (w_kv_last && !w_last_q) begin
        r_q_idx    <= r_q_idx + c_one;
        r_q_issued <= 1'b0;
      end
    end
  end

  // Output buffers: returning read data is pushed the cycle it arrives
  qkv_fifo2 #(.W(Q_VEC_W)) u_q_fifo (
    .clock (clock),
    .reset (reset),
    .push  (r_q_inflight),
    .din   (q_sram_rdata),
    .pop   (w_q_pop),
    .dout  (q_vector),
    .count (w_q_cnt)
  );

  qkv_fifo2 #(.W(K_VEC_W)) u_k_fifo (
    .clock (clock),
    .reset (reset),
    .push  (r_k_inflight),
    .din   (k_sram_rdata),
    .pop   (w_k_pop),
    .dout  (k_vector),
    .count (w_k_cnt)
  );

  qkv_fifo2 #(.W(V_VEC_W)) u_v_fifo (
    .clock (clock),
    .reset (reset),
    .push  (r_v_inflight),
    .din   (v_sram_rdata),
    .pop   (w_v_pop),
    .dout  (v_vector),
    .count (w_v_cnt)
  );

  assign Q_vld_out   = (w_q_cnt != 2'd0);
  assign K_vld_out   = (w_k_cnt != 2'd0);
  assign V_vld_out   = (w_v_cnt != 2'd0);
  assign q_sram_re   = w_q_re;
  assign k_sram_re   = w_k_re;
  assign v_sram_re   = w_v_re;
  assign q_sram_addr = r_q_idx[ADDR_W-1:0];
  assign k_sram_addr = r_k_iss[ADDR_W-1:0];
  assign v_sram_addr = r_v_iss[ADDR_W-1:0];
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);

endmodule

// Two-entry FIFO; the caller never pushes when full or pops when empty.
module qkv_fifo2 #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  // Pointer and occupancy bookkeeping; push+pop together keeps occupancy
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage is unreset: entries are only observed while occupancy is non-zero
  always_ff @(posedge clock) begin
    if (push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule
`default_nettype wire
